// File: rtl/cnt2_seq_pkg.sv
// Shared types and constants for the 2-bit counter sequencing controller.
package cnt2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int CNT_W_DEF = 2;
  localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/cnt2_ud.sv
// CNT_W-bit clearable up/down counter with a registered wrap-around pulse.
module cnt2_ud
  import cnt2_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             dir,
  input  logic             sclr,
  output logic [CNT_W-1:0] Q,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic [CNT_W-1:0] r_q;
  logic             r_wrap;
  logic             w_wrap_step;

  // A clear always wins, so it can never be mistaken for a wrapping step.
  assign w_wrap_step = en & ~sclr &
                       ((dir == DIR_UP) ? (r_q == ALL_ONES) : (r_q == '0));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_step;
      if (sclr)
        r_q <= '0;
      else if (en)
        r_q <= (dir == DIR_UP) ? r_q + 1'b1 : r_q - 1'b1;
    end
  end

  assign Q    = r_q;
  assign wrap = r_wrap;

endmodule

// File: rtl/cnt2_seq_ctrl.sv
// Run/pause/clear sequencer driving the 2-bit counter datapath.
//   state | meaning
//   IDLE  | waiting for start; sclr clears Q
//   RUN   | one step per clock until rem is exhausted
//   PAUSE | hold asserted; Q and rem frozen
//   DONE  | one-cycle done pulse, then back to IDLE
module cnt2_seq_ctrl
  import cnt2_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             dir,
  input  logic [LEN_W-1:0] len,
  input  logic             hold,
  input  logic             sclr,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [CNT_W-1:0] Q
);

  state_t           r_state, w_next;
  logic             r_dir, w_dir_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic             w_en;
  logic             w_sclr;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_dir   <= DIR_UP;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      r_dir   <= w_dir_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_dir_nxt = r_dir;
    w_rem_nxt = r_rem;
    w_en      = 1'b0;
    w_sclr    = 1'b0;
    case (r_state)
      IDLE: begin
        w_sclr = sclr;
        if (start) begin
          w_dir_nxt = dir;
          w_rem_nxt = len;
          w_next    = (len != '0) ? RUN : DONE;
        end
      end
      // Leaving PAUSE steps on the same edge, so each held cycle costs one cycle.
      RUN, PAUSE: begin
        if (hold) begin
          w_next = PAUSE;
        end else begin
          if (r_rem != '0) begin
            w_en      = 1'b1;
            w_rem_nxt = r_rem - 1'b1;
          end
          w_next = (r_rem <= LEN_W'(1)) ? DONE : RUN;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  cnt2_ud #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .clrn (clrn),
    .en   (w_en),
    .dir  (r_dir),
    .sclr (w_sclr),
    .Q    (Q),
    .wrap (wrap)
  );

  assign busy = (r_state == RUN) || (r_state == PAUSE);
  assign done = (r_state == DONE);

endmodule
